yutorina_lsu: RTL and testbench
===============================

Name: yutorina_lsu

Overview:
- Parametrised load/store unit for the MEM stage. Successor to the single-cycle word-only memory control.
- Supports byte, halfword and full-word accesses with byte enables, and sign/zero extension on loads.
- Runs a multi-cycle bus handshake with wait states and a timeout, and drives a pipeline stall while an access is outstanding.
- Sits between the EX/MEM pipeline register and the shared bus; produces the registered MEM result for writeback.

Parameters:
- DATA_W, 32, data bus width in bits; 32 or 64 only. BE_W = DATA_W/8. OFS_W = log2(BE_W).
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, max wait cycles for bus_rdy_ before a bus error; 1..2^16-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ex_en_  in  1  EX stage valid, active low
- ex_mem_op  in  4  0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others treated as NOP
- ex_out  in  DATA_W  ALU result: address for memory ops, passthrough value otherwise
- ex_w_data  in  DATA_W  store data, right-aligned
- bus_addr  out  ADDR_W  word-aligned address; low OFS_W bits are 0
- bus_as_  out  1  address strobe, active low
- bus_rw  out  1  1 = READ, 0 = WRITE
- bus_be  out  BE_W  byte enables, bit i = byte lane i (little endian)
- bus_wr_data  out  DATA_W  store data replicated into the addressed lanes
- bus_rd_data  in  DATA_W  read data, valid when bus_rdy_ = 0
- bus_rdy_  in  1  access complete, active low
- out  out  DATA_W  registered MEM result
- miss_align  out  2  registered: 0 NONE, 1 LOAD, 2 STORE
- bus_err  out  1  registered one-cycle pulse on timeout
- busy  out  1  combinational stall request to the pipeline

Behaviour:
- Reset values:
  - State IDLE, timeout counter 0.
  - out = 0, miss_align = NONE, bus_err = 0.
  - bus_as_ = 1, bus_rw = READ, bus_be = 0, bus_addr = 0, bus_wr_data = 0.
- Widths and alignment:
  - W means DATA_W bits. H is 16 bits; B is 8 bits.
  - ofs = ex_out[OFS_W-1:0].
  - Misaligned when: H and ofs[0] is not 0; W and ofs is not 0. B is never misaligned.
- Byte enables: B sets 1 bit at lane ofs; H sets 2 bits at lanes ofs and ofs+1; W sets all BE_W bits.
- Store data: B replicates ex_w_data[7:0] to every lane; H replicates [15:0]; W passes the word unchanged.
- Load extraction: take the lane(s) at ofs. LB and LH sign-extend to DATA_W; LBU and LHU zero-extend.
- Mapping for DATA_W = 64: LW means a 64-bit load. There is no 32-bit sub-op.
- State IDLE:
  - Condition: ex_en_ = 0 and the op is a memory op.
  - If aligned: register bus_addr, bus_be, bus_rw and bus_wr_data; drive bus_as_ = 0 from the next edge; go to ACCESS; busy = 1 in this cycle.
  - If misaligned: no bus cycle. Next edge: out = 0, miss_align = LOAD or STORE.
  - Otherwise (NOP or ex_en_ = 1): next edge out = ex_out, miss_align = NONE.
- State ACCESS:
  - Hold all bus outputs stable; busy = 1; the counter increments each cycle.
  - Completion: on the first edge with bus_rdy_ = 0, drop bus_as_ = 1 and bus_be = 0.
    - Load: out = extracted read data.
    - Store: out = ex_out.
    - Return to IDLE. busy = 0 in that completing cycle, so the pipeline advances at the same edge.
  - Timeout: if the counter reaches TIMEOUT with bus_rdy_ still 1, release the bus, set out = 0, pulse bus_err for 1 cycle, and return to IDLE.
  - bus_rdy_ = 0 on the TIMEOUT cycle itself counts as completion; completion takes priority.
- Minimum access latency: 2 cycles (issue edge, then a 1-cycle ACCESS with an immediate bus_rdy_).
- Boundary cases:
  - ex_en_ or ex_mem_op changes during ACCESS are ignored; the stall guarantees EX holds.
  - bus_rdy_ = 0 while in IDLE is ignored.
  - Back-to-back memory ops: a new access may issue on the cycle after return to IDLE; no idle gap beyond that is required.
  - Reset mid-ACCESS releases the bus immediately (asynchronous) and discards any pending data.

Test Plan:
- LW at 0x100; bus_rd_data = 0xDEADBEEF; bus_rdy_ = 0 after 3 wait cycles -> bus_as_ low for 4 cycles, bus_be = 4'b1111, busy high 4 cycles, out = 0xDEADBEEF.
- LB and LBU at 0x103, bus_rd_data = 0x80112233 -> LB out = 0xFFFFFF80, LBU out = 0x00000080, bus_be = 4'b1000.
- SH at 0x102 with ex_w_data = 0x0000ABCD -> bus_rw = 0, bus_be = 4'b1100, bus_wr_data = 0xABCDABCD.
- LH at 0x101 and SW at 0x102 -> no bus_as_ pulse; miss_align = LOAD, then STORE; out = 0; busy stays 0.
- TIMEOUT = 4, LW with bus_rdy_ held high -> bus_err pulses once after 4 wait cycles; out = 0; state returns to IDLE; bus_as_ returns to 1.
- Assert reset in the 2nd ACCESS cycle -> bus_as_ = 1 and out = 0 immediately; the next LW after reset completes normally. Repeat the first scenario with DATA_W = 64 (bus_be = 8'hFF).

Source files
------------

// File: rtl/yutorina_lsu.sv
// rtl/yutorina_lsu.sv - MEM-stage load/store unit with wait-state bus handshake
// Sized loads/stores with byte enables, sign/zero extension, timeout and pipeline stall.
module yutorina_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_en_,
  input  logic [3:0]          ex_mem_op,
  input  logic [DATA_W-1:0]   ex_out,
  input  logic [DATA_W-1:0]   ex_w_data,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_as_,
  output logic                bus_rw,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wr_data,
  input  logic [DATA_W-1:0]   bus_rd_data,
  input  logic                bus_rdy_,
  output logic [DATA_W-1:0]   out,
  output logic [1:0]          miss_align,
  output logic                bus_err,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFS_W = $clog2(BE_W);
  localparam int CNT_W = 16;

  localparam logic [1:0] MA_NONE  = 2'd0;
  localparam logic [1:0] MA_LOAD  = 2'd1;
  localparam logic [1:0] MA_STORE = 2'd2;

  typedef enum logic {IDLE, ACCESS} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              as_n_q, as_n_d;
  logic              rw_q, rw_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [1:0]        miss_q, miss_d;
  logic              err_q, err_d;

  // Access context captured at issue so EX may be ignored while the bus is busy
  logic              load_q, load_d;
  logic              sign_q, sign_d;
  size_e             size_q, size_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [DATA_W-1:0] pass_q, pass_d;

  logic              dec_load, dec_store, dec_sign;
  size_e             dec_size;
  logic              mem_req, misalign;
  logic [OFS_W-1:0]  ofs;
  logic [BE_W-1:0]   req_be;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] word_addr;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       rd_lane;
  logic [DATA_W-1:0] ld_data;
  logic              timeout_hit;

  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_sign  = 1'b0;
    dec_size  = SZ_W;
    case (ex_mem_op)
      4'd1: begin dec_load  = 1'b1; dec_size = SZ_B; dec_sign = 1'b1; end
      4'd2: begin dec_load  = 1'b1; dec_size = SZ_B; end
      4'd3: begin dec_load  = 1'b1; dec_size = SZ_H; dec_sign = 1'b1; end
      4'd4: begin dec_load  = 1'b1; dec_size = SZ_H; end
      4'd5: begin dec_load  = 1'b1; dec_size = SZ_W; end
      4'd6: begin dec_store = 1'b1; dec_size = SZ_B; end
      4'd7: begin dec_store = 1'b1; dec_size = SZ_H; end
      4'd8: begin dec_store = 1'b1; dec_size = SZ_W; end
      default: ;
    endcase
  end

  assign ofs     = ex_out[OFS_W-1:0];
  assign mem_req = !ex_en_ && (dec_load || dec_store);

  always_comb begin
    misalign  = 1'b0;
    req_be    = '1;
    req_wdata = ex_w_data;
    case (dec_size)
      SZ_B: begin
        req_be    = BE_W'(1) << ofs;
        req_wdata = {BE_W{ex_w_data[7:0]}};
      end
      SZ_H: begin
        misalign  = ofs[0];
        req_be    = BE_W'(3) << ofs;
        req_wdata = {(BE_W/2){ex_w_data[15:0]}};
      end
      default: begin
        misalign  = (ofs != '0);
        req_be    = '1;
        req_wdata = ex_w_data;
      end
    endcase
  end

  assign word_addr = {ex_out[DATA_W-1:OFS_W], {OFS_W{1'b0}}};
  assign req_addr  = ADDR_W'(word_addr);

  // Right-align the addressed lane(s), then extend to the full word
  assign rd_lane = 16'(bus_rd_data >> {ofs_q, 3'b000});

  always_comb begin
    case (size_q)
      SZ_B:    ld_data = {{(DATA_W-8){sign_q & rd_lane[7]}}, rd_lane[7:0]};
      SZ_H:    ld_data = {{(DATA_W-16){sign_q & rd_lane[15]}}, rd_lane[15:0]};
      default: ld_data = bus_rd_data;
    endcase
  end

  // The last permitted wait cycle; a ready in this same cycle still completes
  assign timeout_hit = bus_rdy_ && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_req && !misalign) state_d = ACCESS;
      end
      ACCESS: begin
        if (!bus_rdy_ || timeout_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    addr_d  = addr_q;
    as_n_d  = as_n_q;
    rw_d    = rw_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    out_d   = out_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    load_d  = load_q;
    sign_d  = sign_q;
    size_d  = size_q;
    ofs_d   = ofs_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (mem_req && misalign) begin
          out_d  = '0;
          miss_d = dec_load ? MA_LOAD : MA_STORE;
        end else if (mem_req) begin
          busy    = 1'b1;
          as_n_d  = 1'b0;
          rw_d    = dec_load;
          be_d    = req_be;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          miss_d  = MA_NONE;
          load_d  = dec_load;
          sign_d  = dec_sign;
          size_d  = dec_size;
          ofs_d   = ofs;
          pass_d  = ex_out;
        end else begin
          out_d  = ex_out;
          miss_d = MA_NONE;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (!bus_rdy_) begin
          busy   = 1'b0;
          as_n_d = 1'b1;
          be_d   = '0;
          out_d  = load_q ? ld_data : pass_q;
        end else if (timeout_hit) begin
          busy   = 1'b0;
          as_n_d = 1'b1;
          be_d   = '0;
          out_d  = '0;
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      as_n_q  <= 1'b1;
      rw_q    <= 1'b1;
      be_q    <= '0;
      wdata_q <= '0;
      out_q   <= '0;
      miss_q  <= MA_NONE;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= SZ_W;
      ofs_q   <= '0;
      pass_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      as_n_q  <= as_n_d;
      rw_q    <= rw_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      load_q  <= load_d;
      sign_q  <= sign_d;
      size_q  <= size_d;
      ofs_q   <= ofs_d;
      pass_q  <= pass_d;
    end
  end

  assign bus_addr    = addr_q;
  assign bus_as_     = as_n_q;
  assign bus_rw      = rw_q;
  assign bus_be      = be_q;
  assign bus_wr_data = wdata_q;
  assign out         = out_q;
  assign miss_align  = miss_q;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_yutorina_lsu.sv
// tb/tb_yutorina_lsu.sv - directed-vector bench for yutorina_lsu (32-bit with short timeout, 64-bit)
module tb_yutorina_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_en_, en64_;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_out, ex_w_data, rd32;
  logic        rdy_;

  logic [31:0] addr32, wr32, out32;
  logic        as32_, rw32, err32, busy32;
  logic [3:0]  be32;
  logic [1:0]  miss32;

  logic [63:0] ex_out64, ex_w_data64, rd64, wr64, out64;
  logic [31:0] addr64;
  logic        as64_, rw64, err64, busy64;
  logic [7:0]  be64;
  logic [1:0]  miss64;

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0]  cap_be;
  logic [31:0] cap_wr, cap_addr, cap_addr64;
  logic        cap_rw, cap_rw64;
  logic [7:0]  cap_be64;
  int          as64_cyc;
  int          as_cyc, busy_cyc, err_cnt;

  assign ex_out64    = {32'h0, ex_out};
  assign ex_w_data64 = {ex_w_data, ex_w_data};

  always #5 clk = ~clk;

  yutorina_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .reset(reset), .ex_en_(ex_en_), .ex_mem_op(ex_mem_op),
    .ex_out(ex_out), .ex_w_data(ex_w_data), .bus_addr(addr32), .bus_as_(as32_),
    .bus_rw(rw32), .bus_be(be32), .bus_wr_data(wr32), .bus_rd_data(rd32),
    .bus_rdy_(rdy_), .out(out32), .miss_align(miss32), .bus_err(err32), .busy(busy32)
  );

  yutorina_lsu #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .reset(reset), .ex_en_(en64_), .ex_mem_op(ex_mem_op),
    .ex_out(ex_out64), .ex_w_data(ex_w_data64), .bus_addr(addr64), .bus_as_(as64_),
    .bus_rw(rw64), .bus_be(be64), .bus_wr_data(wr64), .bus_rd_data(rd64),
    .bus_rdy_(rdy_), .out(out64), .miss_align(miss64), .bus_err(err64), .busy(busy64)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op from IDLE, answers ready after 'waits' rdy-high access cycles.
  task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int waits, input bit with64);
    int acc;
    bit started;
    acc = 0; started = 0;
    as_cyc = 0; busy_cyc = 0; err_cnt = 0; as64_cyc = 0;
    ex_en_ = 1'b0; ex_mem_op = op; ex_out = addr; ex_w_data = wdata; rd32 = rdata; rdy_ = 1'b1;
    if (with64) en64_ = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!as32_) begin
        if (acc == 0) begin
          cap_be = be32; cap_wr = wr32; cap_addr = addr32; cap_rw = rw32;
          cap_be64 = be64; cap_addr64 = addr64; cap_rw64 = rw64;
        end
        rdy_ = (acc == waits) ? 1'b0 : 1'b1;
        acc++;
        as_cyc++;
        started = 1'b1;
      end
      if (!as64_) as64_cyc++;
      #1;
      if (busy32) busy_cyc++;
      @(posedge clk);
      #1;
      if (err32) err_cnt++;
      if (started && as32_) break;
    end
    ex_en_ = 1'b1; en64_ = 1'b1; ex_mem_op = 4'd0; rdy_ = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ex_en_ = 1'b1; en64_ = 1'b1; ex_mem_op = 4'd0;
    ex_out = 32'h0; ex_w_data = 32'h0; rd32 = 32'h0; rd64 = 64'h0; rdy_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_vec("rst_out", out32, 0);
    check_vec("rst_miss", miss32, 0);
    check_vec("rst_err", err32, 0);
    check_vec("rst_as", as32_, 1);
    check_vec("rst_rw", rw32, 1);
    check_vec("rst_be", be32, 0);
    check_vec("rst_addr", addr32, 0);
    check_vec("rst_wr", wr32, 0);
    check_vec("rst_busy", busy32, 0);
    check_vec("rst_wr64", wr64, 0);
    check_vec("rst_busy64", busy64, 0);
    tick();

    // LW with 3 wait cycles on both widths
    rd64 = 64'hDEADBEEF_CAFEF00D;
    do_access(4'd5, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b1);
    check_vec("lw_as_cyc", as_cyc, 4);
    check_vec("lw_busy_cyc", busy_cyc, 4);
    check_vec("lw_err", err_cnt, 0);
    check_vec("lw_be", cap_be, 4'b1111);
    check_vec("lw_addr", cap_addr, 32'h100);
    check_vec("lw_rw", cap_rw, 1);
    check_vec("lw_out", out32, 32'hDEADBEEF);
    check_vec("lw_miss", miss32, 0);
    check_vec("lw_as_after", as32_, 1);
    check_vec("lw_be_after", be32, 0);
    check_vec("lw64_as_cyc", as64_cyc, 4);
    check_vec("lw64_be", cap_be64, 8'hFF);
    check_vec("lw64_addr", cap_addr64, 32'h100);
    check_vec("lw64_rw", cap_rw64, 1);
    check_vec("lw64_out", out64, 64'hDEADBEEF_CAFEF00D);
    check_vec("lw64_miss", miss64, 0);
    check_vec("lw64_err", err64, 0);

    // Byte and halfword loads, minimum latency
    do_access(4'd1, 32'h103, 32'h0, 32'h80112233, 0, 1'b0);
    check_vec("lb_out", out32, 32'hFFFFFF80);
    check_vec("lb_be", cap_be, 4'b1000);
    check_vec("lb_addr", cap_addr, 32'h100);
    check_vec("lb_as_cyc", as_cyc, 1);
    check_vec("lb_busy_cyc", busy_cyc, 1);
    do_access(4'd2, 32'h103, 32'h0, 32'h80112233, 0, 1'b0);
    check_vec("lbu_out", out32, 32'h00000080);
    check_vec("lbu_be", cap_be, 4'b1000);
    do_access(4'd3, 32'h102, 32'h0, 32'h80112233, 0, 1'b0);
    check_vec("lh_out", out32, 32'hFFFF8011);
    check_vec("lh_be", cap_be, 4'b1100);
    do_access(4'd4, 32'h100, 32'h0, 32'h80112233, 2, 1'b0);
    check_vec("lhu_out", out32, 32'h00002233);
    check_vec("lhu_be", cap_be, 4'b0011);
    check_vec("lhu_as_cyc", as_cyc, 3);

    // Stores
    do_access(4'd7, 32'h102, 32'h0000ABCD, 32'h0, 1, 1'b0);
    check_vec("sh_rw", cap_rw, 0);
    check_vec("sh_be", cap_be, 4'b1100);
    check_vec("sh_wr", cap_wr, 32'hABCDABCD);
    check_vec("sh_out", out32, 32'h102);
    check_vec("sh_as_cyc", as_cyc, 2);
    do_access(4'd6, 32'h101, 32'h1234565A, 32'h0, 0, 1'b0);
    check_vec("sb_be", cap_be, 4'b0010);
    check_vec("sb_wr", cap_wr, 32'h5A5A5A5A);
    check_vec("sb_out", out32, 32'h101);
    do_access(4'd8, 32'h104, 32'hCAFEBABE, 32'h0, 0, 1'b0);
    check_vec("sw_be", cap_be, 4'b1111);
    check_vec("sw_wr", cap_wr, 32'hCAFEBABE);
    check_vec("sw_addr", cap_addr, 32'h104);

    // Misaligned accesses never reach the bus
    ex_en_ = 1'b0; ex_mem_op = 4'd3; ex_out = 32'h101;
    #1;
    check_vec("mis_lh_busy", busy32, 0);
    tick();
    check_vec("mis_lh_as", as32_, 1);
    check_vec("mis_lh_miss", miss32, 1);
    check_vec("mis_lh_out", out32, 0);
    ex_mem_op = 4'd8; ex_out = 32'h102;
    #1;
    check_vec("mis_sw_busy", busy32, 0);
    tick();
    check_vec("mis_sw_as", as32_, 1);
    check_vec("mis_sw_miss", miss32, 2);
    check_vec("mis_sw_out", out32, 0);

    // NOP passthrough; ready in IDLE is ignored
    ex_mem_op = 4'd0; ex_out = 32'h55; rdy_ = 1'b0;
    tick();
    check_vec("nop_out", out32, 32'h55);
    check_vec("nop_miss", miss32, 0);
    check_vec("nop_as", as32_, 1);
    ex_mem_op = 4'd9; ex_out = 32'h66;
    #1;
    check_vec("op9_busy", busy32, 0);
    tick();
    check_vec("op9_out", out32, 32'h66);
    check_vec("op9_as", as32_, 1);
    rdy_ = 1'b1; ex_en_ = 1'b1; ex_mem_op = 4'd0;
    tick();

    // Timeout after 4 wait cycles
    do_access(4'd5, 32'h300, 32'h0, 32'h11111111, 1000, 1'b0);
    check_vec("to_as_cyc", as_cyc, 4);
    check_vec("to_err_cnt", err_cnt, 1);
    check_vec("to_err", err32, 1);
    check_vec("to_out", out32, 0);
    check_vec("to_as", as32_, 1);
    tick();
    check_vec("to_err_clr", err32, 0);
    check_vec("to_as_idle", as32_, 1);

    // Asynchronous reset in the 2nd access cycle
    ex_en_ = 1'b1; ex_mem_op = 4'd0; ex_out = 32'h200;
    tick();
    check_vec("pre_rst_out", out32, 32'h200);
    ex_en_ = 1'b0; ex_mem_op = 4'd5; rdy_ = 1'b1;
    tick();
    tick();
    check_vec("mid_as", as32_, 0);
    #2;
    reset = 1'b1;
    #1;
    check_vec("mid_rst_as", as32_, 1);
    check_vec("mid_rst_out", out32, 0);
    check_vec("mid_rst_be", be32, 0);
    reset = 1'b0;
    ex_en_ = 1'b1; ex_mem_op = 4'd0;
    tick();
    do_access(4'd5, 32'h200, 32'h0, 32'h13579BDF, 0, 1'b0);
    check_vec("post_rst_out", out32, 32'h13579BDF);
    check_vec("post_rst_as_cyc", as_cyc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
